// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes bclk/lrclk/sdata into clk, deserializes left/right
// slots and hands complete stereo pairs to a downstream FIFO.
//
// state | meaning
// SYNC  | waiting for an lrclk 1->0 slot end; all bits discarded
// LEFT  | collecting the left slot
// RIGHT | collecting the right slot; a good slot end completes the frame

module i2s_rx #(
    parameter int WORDSIZE = 32,
    parameter int MIN_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bclk,
    input  logic                lrclk,
    input  logic                sdata,
    input  logic                full,
    output logic                write_en,
    output logic [WORDSIZE-1:0] data_left_out,
    output logic [WORDSIZE-1:0] data_right_out,
    output logic                overflow,
    output logic                frame_err
);

    localparam int CW = $clog2(WORDSIZE + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(WORDSIZE + 1);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_BITS);
    localparam logic [WORDSIZE-1:0] MSB_ONE = {1'b1, {(WORDSIZE-1){1'b0}}};

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t              state;
    logic [2:0]          bclk_sync;
    logic [1:0]          lrclk_sync;
    logic [1:0]          sdata_sync;
    logic                lr_prev;
    logic [CW-1:0]       bitcnt;
    logic [WORDSIZE-1:0] shift_word;
    logic [WORDSIZE-1:0] left_hold;

    logic                sample;
    logic                lr_cur;
    logic                slot_end;
    logic [CW-1:0]       cnt_next;
    logic                cnt_ok;
    logic [WORDSIZE-1:0] word_next;

    // bclk carries one extra stage for edge detection; lrclk/sdata stay aligned to bclk_sync[1]
    assign sample   = bclk_sync[1] & ~bclk_sync[2];
    assign lr_cur   = lrclk_sync[1];
    assign slot_end = lr_cur != lr_prev;
    assign cnt_next = (bitcnt == CNT_MAX) ? CNT_MAX : bitcnt + CW'(1);
    assign cnt_ok   = cnt_next >= MIN_CNT;

    // Shifting the marker past the word width naturally drops bits beyond WORDSIZE
    always_comb begin
        word_next = shift_word | ((MSB_ONE >> bitcnt) & {WORDSIZE{sdata_sync[1]}});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= SYNC;
            bclk_sync      <= '0;
            lrclk_sync     <= '0;
            sdata_sync     <= '0;
            lr_prev        <= 1'b0;
            bitcnt         <= '0;
            shift_word     <= '0;
            left_hold      <= '0;
            write_en       <= 1'b0;
            frame_err      <= 1'b0;
            overflow       <= 1'b0;
            data_left_out  <= '0;
            data_right_out <= '0;
        end else begin
            bclk_sync  <= {bclk_sync[1:0], bclk};
            lrclk_sync <= {lrclk_sync[0], lrclk};
            sdata_sync <= {sdata_sync[0], sdata};
            write_en   <= 1'b0;
            frame_err  <= 1'b0;
            if (sample) begin
                lr_prev <= lr_cur;
                if (slot_end) begin
                    bitcnt     <= '0;
                    shift_word <= '0;
                end else begin
                    bitcnt     <= cnt_next;
                    shift_word <= word_next;
                end
                case (state)
                    SYNC: begin
                        if (slot_end && lr_prev)
                            state <= LEFT;
                    end
                    LEFT: begin
                        if (slot_end) begin
                            if (cnt_ok) begin
                                left_hold <= word_next;
                                state     <= RIGHT;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= SYNC;
                            end
                        end
                    end
                    RIGHT: begin
                        if (slot_end) begin
                            if (cnt_ok) begin
                                if (full) begin
                                    overflow <= 1'b1;
                                end else begin
                                    data_left_out  <= left_hold;
                                    data_right_out <= word_next;
                                    write_en       <= 1'b1;
                                end
                                state <= LEFT;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= SYNC;
                            end
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx: drives I2S frames and checks every stereo write,
// frame error and the overflow flag against a frame-level reference model.

module tb_i2s_rx;

    localparam int WS   = 32;
    localparam int MINB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          bclk = 1'b0;
    logic          lrclk = 1'b0;
    logic          sdata = 1'b0;
    logic          full = 1'b0;
    logic          write_en;
    logic          overflow;
    logic          frame_err;
    logic [WS-1:0] data_left_out;
    logic [WS-1:0] data_right_out;

    int n_checks = 0;
    int n_fail   = 0;
    int got_ferr = 0;
    int exp_ferr = 0;
    int got_writes = 0;
    bit locked  = 1'b0;
    bit exp_ovf = 1'b0;
    logic [WS-1:0] exp_l_q[$];
    logic [WS-1:0] exp_r_q[$];

    i2s_rx #(.WORDSIZE(WS), .MIN_BITS(MINB)) dut (
        .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .full(full), .write_en(write_en), .data_left_out(data_left_out),
        .data_right_out(data_right_out), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // An n-bit slot value, MSB first, left-justified into WS bits (excess LSBs dropped)
    function automatic logic [WS-1:0] justify(input logic [63:0] v, input int n);
        if (n >= WS) return WS'(v >> (n - WS));
        else         return WS'(v << (WS - n));
    endfunction

    // Last bit of each slot is sent with lrclk already showing the next channel
    task automatic send_slot(input bit ch, input logic [63:0] v, input int n, input bit next_ch);
        for (int j = 0; j < n; j++) begin
            bclk  = 1'b0;
            lrclk = (j == n - 1) ? next_ch : ch;
            sdata = v[6'(n - 1 - j)];
            #40;
            bclk = 1'b1;
            #40;
        end
    endtask

    task automatic send_frame(input logic [63:0] lv, input int nl, input logic [63:0] rv,
                              input int nr, input bit f);
        if (locked) begin
            if (nl < MINB) begin
                exp_ferr++;
                locked = 1'b1;
            end else if (nr < MINB) begin
                exp_ferr++;
                locked = 1'b0;
            end else if (f) begin
                exp_ovf = 1'b1;
            end else begin
                exp_l_q.push_back(justify(lv, nl));
                exp_r_q.push_back(justify(rv, nr));
            end
        end else begin
            locked = 1'b1;
        end
        full = f;
        send_slot(1'b0, lv, nl, 1'b1);
        send_slot(1'b1, rv, nr, 1'b0);
        bclk = 1'b0;
        #30;
        full = 1'b0;
        check("overflow", overflow, exp_ovf);
        check("frame_err_count", got_ferr, exp_ferr);
        check("pending_writes", exp_l_q.size(), 0);
    endtask

    function automatic logic [63:0] rand_val(input int n);
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v & ((64'd1 << n) - 64'd1);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) got_ferr++;
            if (write_en) begin
                got_writes++;
                if (exp_l_q.size() == 0) begin
                    check("write_when_none_expected", write_en, 0);
                end else begin
                    check("data_left", data_left_out, exp_l_q.pop_front());
                    check("data_right", data_right_out, exp_r_q.pop_front());
                end
            end
        end
    end

    initial begin
        int nl, nr, w0;
        bit f;
        #22;
        check("rst_write_en", write_en, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_left", data_left_out, 0);
        check("rst_right", data_right_out, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // First frame after reset only establishes alignment
        send_frame(64'hA5A50001, 32, 64'h5A5A8000, 32, 1'b0);
        check("basic_first_no_write", got_writes, 0);
        send_frame(64'hA5A50001, 32, 64'h5A5A8000, 32, 1'b0);
        check("basic_left", data_left_out, 32'hA5A50001);
        check("basic_right", data_right_out, 32'h5A5A8000);

        send_frame(64'h123456, 24, 64'hABCDEF, 24, 1'b0);
        check("slot24_left", data_left_out, 32'h12345600);

        send_frame({24'd0, 32'hDEADBEEF, 8'($urandom)}, 40,
                   {24'd0, 32'hCAFEF00D, 8'($urandom)}, 40, 1'b0);
        check("slot40_left", data_left_out, 32'hDEADBEEF);
        check("slot40_right", data_right_out, 32'hCAFEF00D);

        send_frame(64'h11111111, 32, 64'h22222222, 32, 1'b1);
        check("ovf_hold_left", data_left_out, 32'hDEADBEEF);
        check("ovf_hold_right", data_right_out, 32'hCAFEF00D);
        send_frame(64'h33333333, 32, 64'h44444444, 32, 1'b0);

        w0 = got_writes;
        send_frame(64'h5A, 8, 64'h77777777, 32, 1'b0);
        check("short_no_write", got_writes, w0);
        send_frame(64'h13579BDF, 32, 64'h2468ACE0, 32, 1'b0);

        for (int k = 0; k < 14; k++) begin
            nl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 40));
            nr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 40));
            f  = ($urandom_range(0, 4) == 0);
            send_frame(rand_val(nl), nl, rand_val(nr), nr, f);
        end

        // Reset in the middle of a left slot
        send_frame(64'h0F0F0F0F, 32, 64'hF0F0F0F0, 32, 1'b0);
        send_slot(1'b0, 64'h3C3C3C3C, 10, 1'b0);
        bclk = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_write_en", write_en, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_left", data_left_out, 0);
        check("midrst_right", data_right_out, 0);
        exp_ovf = 1'b0;
        locked  = 1'b0;
        #50;
        @(negedge clk);
        rst = 1'b1;
        w0 = got_writes;
        send_slot(1'b0, 64'h3C3C3C3C, 22, 1'b1);
        send_slot(1'b1, 64'h99999999, 32, 1'b0);
        locked = 1'b1;
        bclk = 1'b0;
        #30;
        check("midrst_partial_dropped", got_writes, w0);
        send_frame(64'hFEEDFACE, 32, 64'h0BADC0DE, 32, 1'b0);
        check("midrst_resume_left", data_left_out, 32'hFEEDFACE);

        #200;
        check("final_pending", exp_l_q.size(), 0);
        check("final_frame_err", got_ferr, exp_ferr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
